btn_conditioner: RTL and testbench

- Input stage between the raw DE1 push-buttons (btn_A..btn_D, active-low) and the game FSM, ship, and ammunition logic.
- Per button: synchronizes to clk, debounces, and produces a clean level, one-cycle press/release pulses, and an auto-repeat pulse stream for held buttons.
- Replaces the direct use of raw key levels and ad-hoc edge detection in the game top.

---
 rtl/btn_pkg.sv | 30 +++
 rtl/btn_conditioner_if.sv | 41 ++++
 rtl/btn_channel.sv | 141 ++++++++++++++
 rtl/btn_conditioner.sv | 68 ++++++
 tb/tb_btn_conditioner.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// btn_pkg: shared types and constants for the push-button conditioner
// Rev 1.0
// ------------------------------------------------------------------
package btn_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  localparam int         DEF_NUM_BTN         = 4;
  localparam int         DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int         DEF_REPEAT_DELAY    = 25000000;
  localparam int         DEF_REPEAT_PERIOD   = 5000000;
  localparam logic [3:0] DEF_REPEAT_MASK     = 4'b0011;

  localparam int BTN_A = 0;
  localparam int BTN_B = 1;
  localparam int BTN_C = 2;
  localparam int BTN_D = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_conditioner_if.sv
`default_nettype none
// ------------------------------------------------------------------
// btn_conditioner_if: raw keys in, conditioned levels and pulses out
// Rev 1.0
// ------------------------------------------------------------------
interface btn_conditioner_if
  import btn_pkg::*;
#(
  parameter int NUM_BTN = DEF_NUM_BTN
);

  logic [NUM_BTN-1:0] btn_raw;
  logic               enable;
  logic [NUM_BTN-1:0] btn_level;
  logic [NUM_BTN-1:0] btn_press;
  logic [NUM_BTN-1:0] btn_release;
  logic [NUM_BTN-1:0] btn_repeat;
  logic               any_press;

  modport master (
    output btn_raw,
    output enable,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_repeat,
    input  any_press
  );

  modport slave (
    input  btn_raw,
    input  enable,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_repeat,
    output any_press
  );

endinterface
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ------------------------------------------------------------------
// btn_channel: synchronizer, debouncer and auto-repeat FSM for one key
// Rev 1.0
// ------------------------------------------------------------------
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  wire  clk,
  input  wire  reset,
  input  wire  btn_raw_i,
  output logic level_o,
  output logic press_evt_o,
  output logic release_evt_o,
  output logic repeat_evt_o
);

  localparam int DW   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int RMAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  localparam logic [DW-1:0] DCNT_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          sample;
  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] dcnt_d;
  logic          level_q;
  logic          level_d;
  logic          rise;
  logic          fall;
  rpt_state_e    state_q;
  rpt_state_e    state_d;
  logic [RW-1:0] rcnt_q;
  logic [RW-1:0] rcnt_d;
  logic          rpt_pulse;

  // Keys idle high, so the chain resets to "released".
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign sample = ~sync2_q;

  always_comb begin
    dcnt_d  = dcnt_q;
    level_d = level_q;
    if (sample == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_LAST) begin
      level_d = sample;
      dcnt_d  = '0;
    end else begin
      dcnt_d = dcnt_q + 1'b1;
    end
  end

  assign rise = level_d & ~level_q;
  assign fall = ~level_d & level_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      dcnt_q  <= '0;
      level_q <= 1'b0;
      state_q <= RPT_IDLE;
      rcnt_q  <= '0;
    end else begin
      dcnt_q  <= dcnt_d;
      level_q <= level_d;
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RPT_IDLE:   if (rise && REPEAT_EN) state_d = RPT_DELAY;
      RPT_DELAY: begin
        if (fall)                      state_d = RPT_IDLE;
        else if (rcnt_q == DELAY_LAST) state_d = RPT_REPEAT;
      end
      RPT_REPEAT: if (fall) state_d = RPT_IDLE;
      default:    state_d = RPT_IDLE;
    endcase
  end

  // A release always wins over an expiring counter in the same cycle.
  always_comb begin
    rpt_pulse = 1'b0;
    rcnt_d    = rcnt_q;
    case (state_q)
      RPT_IDLE: begin
        rcnt_d    = '0;
        rpt_pulse = rise;
      end
      RPT_DELAY: begin
        if (fall) begin
          rcnt_d = '0;
        end else if (rcnt_q == DELAY_LAST) begin
          rpt_pulse = 1'b1;
          rcnt_d    = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      RPT_REPEAT: begin
        if (fall) begin
          rcnt_d = '0;
        end else if (rcnt_q == PERIOD_LAST) begin
          rpt_pulse = 1'b1;
          rcnt_d    = '0;
        end else begin
          rcnt_d = rcnt_q + 1'b1;
        end
      end
      default: rcnt_d = '0;
    endcase
  end

  assign level_o       = level_q;
  assign press_evt_o   = rise;
  assign release_evt_o = fall;
  assign repeat_evt_o  = rpt_pulse;

endmodule
`default_nettype wire

// File: rtl/btn_conditioner.sv
`default_nettype none
// ------------------------------------------------------------------
// btn_conditioner: per-key conditioning with gated, registered pulses
// Rev 1.0
// ------------------------------------------------------------------
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int                 NUM_BTN         = DEF_NUM_BTN,
  parameter int                 DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int                 REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int                 REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter logic [NUM_BTN-1:0] REPEAT_MASK     = NUM_BTN'(DEF_REPEAT_MASK)
) (
  input wire                 clk,
  input wire                 reset,
  btn_conditioner_if.slave   bus
);

  logic [NUM_BTN-1:0] level_w;
  logic [NUM_BTN-1:0] press_d;
  logic [NUM_BTN-1:0] release_d;
  logic [NUM_BTN-1:0] repeat_d;
  logic [NUM_BTN-1:0] press_q;
  logic [NUM_BTN-1:0] release_q;
  logic [NUM_BTN-1:0] repeat_q;
  logic               any_q;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
    btn_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD),
      .REPEAT_EN       (REPEAT_MASK[i])
    ) u_chan (
      .clk           (clk),
      .reset         (reset),
      .btn_raw_i     (bus.btn_raw[i]),
      .level_o       (level_w[i]),
      .press_evt_o   (press_d[i]),
      .release_evt_o (release_d[i]),
      .repeat_evt_o  (repeat_d[i])
    );
  end

  // Pulses register alongside the level so they coincide with its change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      press_q   <= '0;
      release_q <= '0;
      repeat_q  <= '0;
      any_q     <= 1'b0;
    end else begin
      press_q   <= press_d   & {NUM_BTN{bus.enable}};
      release_q <= release_d & {NUM_BTN{bus.enable}};
      repeat_q  <= repeat_d  & {NUM_BTN{bus.enable}};
      any_q     <= bus.enable & (|press_d);
    end
  end

  assign bus.btn_level   = level_w;
  assign bus.btn_press   = press_q;
  assign bus.btn_release = release_q;
  assign bus.btn_repeat  = repeat_q;
  assign bus.any_press   = any_q;

endmodule
`default_nettype wire

// File: tb/tb_btn_conditioner.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_btn_conditioner: directed scenarios with a pulse-event scoreboard
// Rev 1.0
// ------------------------------------------------------------------
module tb_btn_conditioner;
  import btn_pkg::*;

  localparam int NB = 4;

  typedef struct packed {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rep;
    logic       anyp;
  } evt_t;

  logic clk = 1'b0;
  logic reset;
  int   edge_n = 0;
  int   checks = 0;
  int   errors = 0;
  evt_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  btn_conditioner_if #(.NUM_BTN(NB)) bus ();

  btn_conditioner #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5),
    .REPEAT_MASK     (4'b0011)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Inserted in cycle order so the monitor can always pop the front.
  task automatic expect_evt(input int cyc, input logic [3:0] p, input logic [3:0] r,
                            input logic [3:0] rp, input logic a);
    evt_t e;
    int   k;
    e.cyc = cyc; e.press = p; e.rel = r; e.rep = rp; e.anyp = a;
    k = 0;
    while (k < exp_q.size() && exp_q[k].cyc <= cyc) k++;
    exp_q.insert(k, e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    evt_t e;
    logic [12:0] obs;
    obs = {bus.btn_press, bus.btn_release, bus.btn_repeat, bus.any_press};
    if (obs != '0) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_pulse cycle=%0d observed=%b expected=none", edge_n, obs);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        assert (edge_n === e.cyc) else begin
          errors++;
          $error("FAIL pulse_cycle observed=%0d expected=%0d", edge_n, e.cyc);
        end
        checks++;
        assert (obs === {e.press, e.rel, e.rep, e.anyp}) else begin
          errors++;
          $error("FAIL pulse_vector cycle=%0d observed=%b expected=%b", edge_n, obs,
                 {e.press, e.rel, e.rep, e.anyp});
        end
      end
    end
  end

  initial begin
    int t;
    int p;
    reset       = 1'b0;
    bus.btn_raw = '1;
    bus.enable  = 1'b1;
    tick(3);
    chk("reset_outputs", 32'({bus.btn_level, bus.btn_press, bus.btn_release,
                              bus.btn_repeat, bus.any_press}), 32'd0);
    reset = 1'b1;
    tick(2);

    // Clean press and auto-repeat on A, released so the fall lands on a repeat slot.
    t = edge_n;
    p = t + 6;
    bus.btn_raw[BTN_A] = 1'b0;
    expect_evt(p, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    for (int k = 0; k < 7; k++) expect_evt(p + 10 + 5 * k, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    tick(5);
    chk("a_level_before", 32'(bus.btn_level[BTN_A]), 32'd0);
    tick(1);
    chk("a_level_rise", 32'(bus.btn_level[BTN_A]), 32'd1);
    tick(39);
    bus.btn_raw[BTN_A] = 1'b1;
    expect_evt(p + 45, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    tick(5);
    chk("a_level_hold", 32'(bus.btn_level[BTN_A]), 32'd1);
    tick(1);
    chk("a_level_fall", 32'(bus.btn_level[BTN_A]), 32'd0);
    tick(15);

    // Three-cycle glitch on B must be rejected.
    bus.btn_raw[BTN_B] = 1'b0;
    tick(3);
    bus.btn_raw[BTN_B] = 1'b1;
    for (int k = 0; k < 20; k += 5) begin
      tick(5);
      chk("b_glitch_level", 32'(bus.btn_level[BTN_B]), 32'd0);
    end

    // D has repeat disabled: a single repeat pulse with the press.
    t = edge_n;
    bus.btn_raw[BTN_D] = 1'b0;
    expect_evt(t + 6, 4'b1000, 4'b0000, 4'b1000, 1'b1);
    tick(6);
    chk("d_level_rise", 32'(bus.btn_level[BTN_D]), 32'd1);
    tick(40);
    t = edge_n;
    bus.btn_raw[BTN_D] = 1'b1;
    expect_evt(t + 6, 4'b0000, 4'b1000, 4'b0000, 1'b0);
    tick(12);
    chk("d_level_fall", 32'(bus.btn_level[BTN_D]), 32'd0);

    // B and C pressed while disabled; repeats on B resume after re-enable.
    bus.enable = 1'b0;
    t = edge_n;
    p = t + 6;
    bus.btn_raw[BTN_B] = 1'b0;
    bus.btn_raw[BTN_C] = 1'b0;
    tick(6);
    chk("bc_level_disabled", 32'(bus.btn_level[2:1]), 32'd3);
    tick(12);
    bus.enable = 1'b1;
    expect_evt(p + 15, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    expect_evt(p + 20, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    expect_evt(p + 25, 4'b0000, 4'b0000, 4'b0010, 1'b0);
    tick(9);
    bus.btn_raw[BTN_B] = 1'b1;
    bus.btn_raw[BTN_C] = 1'b1;
    expect_evt(p + 27, 4'b0000, 4'b0110, 4'b0000, 1'b0);
    tick(12);
    chk("bc_level_fall", 32'(bus.btn_level[2:1]), 32'd0);

    // Reset while A is in REPEAT, key still held.
    t = edge_n;
    p = t + 6;
    bus.btn_raw[BTN_A] = 1'b0;
    expect_evt(p, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    expect_evt(p + 10, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    expect_evt(p + 15, 4'b0000, 4'b0000, 4'b0001, 1'b0);
    tick(23);
    reset = 1'b0;
    tick(1);
    chk("midrun_reset_outputs", 32'({bus.btn_level, bus.btn_press, bus.btn_release,
                                     bus.btn_repeat, bus.any_press}), 32'd0);
    reset = 1'b1;
    expect_evt(p + 24, 4'b0001, 4'b0000, 4'b0001, 1'b1);
    tick(5);
    chk("a_relevel_before", 32'(bus.btn_level[BTN_A]), 32'd0);
    tick(1);
    chk("a_relevel_rise", 32'(bus.btn_level[BTN_A]), 32'd1);
    tick(1);
    bus.btn_raw[BTN_A] = 1'b1;
    expect_evt(p + 31, 4'b0000, 4'b0001, 4'b0000, 1'b0);
    tick(15);
    chk("a_final_level", 32'(bus.btn_level[BTN_A]), 32'd0);

    chk("events_outstanding", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
